fan_battery_ctrl: RTL
=====================

# fan_battery_ctrl

Parametrised battery model for the fan controller. Tracks charge level and derives charge/discharge rates per fan state from one millisecond strobe, replacing per-rate external timer inputs. Adds saturating arithmetic, full/empty/low-warning flags with hysteresis, and a registered stop request to the fan FSM. Sits between the timer prescaler and the fan state machine; `level` drives the display.

## Interface
Parameters:
- `LEVEL_W`, 8: width of `level`.
- `LEVEL_MAX`, 99: full level; must be < 2^LEVEL_W.
- `LEVEL_INIT`, 99: level after reset; must be ≤ LEVEL_MAX.
- `CNT_W`, 12: width of the period counter.
- `CHG_MS0..CHG_MS3`, 100/200/250/500: ms per +1 while charging, indexed by `fan_state`.
- `DIS_MS1..DIS_MS3`, 500/250/200: ms per −1 while discharging in fan states 1..3.
- `LOW_TH`, 20: low warning asserts at level ≤ LOW_TH.
- `LOW_HYST`, 5: low warning clears at level ≥ LOW_TH+LOW_HYST.
- `RESTART_LVL`, 10: `stop_req` clears at level ≥ RESTART_LVL.
- All period parameters are ≥ 1 and < 2^CNT_W.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  async active-high reset.
- `tick_ms`  in  1  one-cycle 1 ms strobe.
- `charge_en`  in  1  charger switch (sw0).
- `fan_state`  in  2  0 = neutral; 1..3 = speed.
- `level`  out  LEVEL_W  current charge, 0..LEVEL_MAX.
- `empty`  out  1  level == 0.
- `full`  out  1  level == LEVEL_MAX.
- `low_warn`  out  1  low-battery warning, with hysteresis.
- `stop_req`  out  1  request to force the fan to neutral.
- `phase`  out  2  0 = HOLD, 1 = CHG, 2 = DIS.

## Operation
- Phase is derived combinationally:
  - CHG when `charge_en`.
  - DIS when `!charge_en && fan_state != 0`.
  - HOLD otherwise.
  - `phase` output is the registered copy.
- Period select:
  - CHG uses `CHG_MSn` with n = fan_state.
  - DIS uses `DIS_MSn`.
  - HOLD has no period: counter held at 0, level unchanged.
- Period counter `cnt`, CNT_W bits:
  - Increments on `tick_ms`.
  - When `tick_ms` arrives with `cnt == period-1`: a step fires and `cnt` returns to 0.
- Counter restart: a change of phase or of `fan_state` between consecutive cycles clears `cnt` to 0 that cycle. No step fires that cycle, even if `tick_ms` is high.
- Step in CHG: level +1, saturating at LEVEL_MAX. At LEVEL_MAX the counter keeps running and no write occurs.
- Step in DIS: level −1, saturating at 0.
- Flags are all registered and updated on the same edge as `level`, computed from the next level:
  - `empty` = (next == 0).
  - `full` = (next == LEVEL_MAX).
  - `low_warn` sets at next ≤ LOW_TH, clears at next ≥ LOW_TH+LOW_HYST, otherwise holds.
  - `stop_req` sets at next == 0, clears at next ≥ RESTART_LVL, otherwise holds.
- The block does not gate `fan_state`. The fan FSM must honour `stop_req`. While the fan is neutral the level is stable, so `stop_req` persists until recharged.

## Timing
- Reset values:
  - `level` = LEVEL_INIT.
  - `cnt` = 0.
  - `phase` = HOLD.
  - `empty`, `full` per LEVEL_INIT.
  - `low_warn` = (LEVEL_INIT ≤ LOW_TH).
  - `stop_req` = (LEVEL_INIT == 0).
- Step latency: terminal `tick_ms` sampled at edge k; new `level` and flags visible after edge k.
- First step after a phase or state change occurs on the period-th `tick_ms` strictly after the change cycle.
- `charge_en` and `fan_state` are sampled synchronously; their synchronisation is upstream.
- Reset mid-period: all state returns to reset values immediately (async); counting restarts from 0 after release.

## Structure
- Package `fan_pkg`:
  - Phase encoding constants `PH_HOLD`, `PH_CHG`, `PH_DIS`.
  - Fan state encodings `FAN_OFF`, `FAN_S1..S3`, shared with the fan FSM.
- Natural sub-module `period_counter`:
  - Parameterised CNT_W.
  - Inputs: `clr`, `tick`, `period`.
  - Output: `step`.
- Level register, saturation and flag/hysteresis logic live in the top module.

## Test plan
- Reset with defaults, then `charge_en=0`, `fan_state=3`, 200 ticks → `level`=98 after the 200th tick; `phase`=DIS.
- `charge_en=1`, `fan_state=0`, level 97, 300 ticks → 98, 99, then holds at 99; `full`=1 from the 200th tick.
- DIS state 3 down from 21 → `low_warn` rises at 20; charge back → `low_warn` stays high through 24 and clears at 25.
- Discharge to 0 → `empty`=1 and `stop_req`=1 on the same edge. Neutral with charger off, 1000 ticks → level stays 0. Charge in state 0 → `empty` clears at 1; `stop_req` clears at 10.
- `fan_state` change 1→2 after 499 ticks in DIS → no step at that point; next decrement after 250 further ticks. `tick_ms` high in the change cycle is ignored.
- Assert `rst` mid-period with level 50 → `level`=99 and `cnt`=0 asynchronously; the first post-release step needs a full period.

Source files
------------

// File: rtl/fan_battery_ctrl_pkg.sv
// Shared encodings for the fan controller: battery phases and fan speed states.
// The fan state machine imports the same constants so both sides agree on them.
package fan_pkg;

  // Battery phase, also exported on the phase output
  typedef enum logic [1:0] {
    PH_HOLD = 2'd0,
    PH_CHG  = 2'd1,
    PH_DIS  = 2'd2
  } phase_t;

  // Fan speed states as driven by the fan state machine
  localparam logic [1:0] FAN_OFF = 2'd0;
  localparam logic [1:0] FAN_S1  = 2'd1;
  localparam logic [1:0] FAN_S2  = 2'd2;
  localparam logic [1:0] FAN_S3  = 2'd3;

  // The charger has priority; a running fan drains; otherwise the level rests
  function automatic phase_t phase_of(input logic charge_en, input logic [1:0] fan_state);
    phase_t ph;
    ph = PH_HOLD;
    if (charge_en) begin
      ph = PH_CHG;
    end else if (fan_state != FAN_OFF) begin
      ph = PH_DIS;
    end
    return ph;
  endfunction

endpackage

// File: rtl/fan_battery_ctrl_if.sv
// Bundle of the battery model's control inputs and status outputs.
// The master side (fan FSM / prescaler / bench) drives the strobe and mode;
// the slave side (the battery model) returns level, flags and phase.
interface fan_battery_ctrl_if #(
  parameter int LEVEL_W = 8
);

  logic               tick_ms;
  logic               charge_en;
  logic [1:0]         fan_state;
  logic [LEVEL_W-1:0] level;
  logic               empty;
  logic               full;
  logic               low_warn;
  logic               stop_req;
  logic [1:0]         phase;

  modport master (
    output tick_ms,
    output charge_en,
    output fan_state,
    input  level,
    input  empty,
    input  full,
    input  low_warn,
    input  stop_req,
    input  phase
  );

  modport slave (
    input  tick_ms,
    input  charge_en,
    input  fan_state,
    output level,
    output empty,
    output full,
    output low_warn,
    output stop_req,
    output phase
  );

endinterface

// File: rtl/fan_battery_ctrl_period_counter.sv
// Millisecond period counter: counts tick strobes and pulses step on the tick
// that completes a period. clr restarts the period and suppresses any step in
// that cycle, so a restart never produces a step on its own.
module period_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] period,
  output logic             step
);

  logic [CNT_W-1:0] cnt;
  logic             terminal;

  // Treat anything at or past the last count as terminal so a shortened period
  // can never leave the counter stranded above it.
  assign terminal = (cnt >= (period - CNT_W'(1)));
  assign step     = tick && !clr && terminal;

  // Count ticks, wrap to zero on the completing tick, restart on clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      if (terminal) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fan_battery_ctrl.sv
// Battery model for the fan controller. Derives a charge/discharge rate from
// the fan state, steps a saturating level on completed periods of the 1 ms
// strobe, and keeps full/empty/low-warning/stop-request flags in step with it.
module fan_battery_ctrl
  import fan_pkg::*;
#(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 99,
  parameter int LEVEL_INIT  = 99,
  parameter int CNT_W       = 12,
  parameter int CHG_MS0     = 100,
  parameter int CHG_MS1     = 200,
  parameter int CHG_MS2     = 250,
  parameter int CHG_MS3     = 500,
  parameter int DIS_MS1     = 500,
  parameter int DIS_MS2     = 250,
  parameter int DIS_MS3     = 200,
  parameter int LOW_TH      = 20,
  parameter int LOW_HYST    = 5,
  parameter int RESTART_LVL = 10
) (
  input logic              clk,
  input logic              rst,
  fan_battery_ctrl_if.slave bus
);

  localparam logic [LEVEL_W-1:0] LVL_MAX     = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_INIT    = LEVEL_W'(LEVEL_INIT);
  localparam logic [LEVEL_W-1:0] LVL_LOW_SET = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] LVL_LOW_CLR = LEVEL_W'(LOW_TH + LOW_HYST);
  localparam logic [LEVEL_W-1:0] LVL_RESTART = LEVEL_W'(RESTART_LVL);

  localparam logic INIT_EMPTY = (LEVEL_INIT == 0);
  localparam logic INIT_FULL  = (LEVEL_INIT == LEVEL_MAX);
  localparam logic INIT_LOW   = (LEVEL_INIT <= LOW_TH);
  localparam logic INIT_STOP  = (LEVEL_INIT == 0);

  phase_t             cur_phase;
  phase_t             phase_q;
  logic [1:0]         fan_q;
  logic               restart;
  logic               clr;
  logic [CNT_W-1:0]   period;
  logic               step;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_next;
  logic               empty_q;
  logic               full_q;
  logic               low_q;
  logic               low_next;
  logic               stop_q;
  logic               stop_next;

  assign cur_phase = phase_of(bus.charge_en, bus.fan_state);

  // Any change of phase or fan speed starts a fresh period; in HOLD the counter idles at zero
  assign restart = (cur_phase != phase_q) || (bus.fan_state != fan_q);
  assign clr     = restart || (cur_phase == PH_HOLD);

  // Select the period length for the current phase and fan speed
  always_comb begin
    period = CNT_W'(1);
    case (cur_phase)
      PH_CHG: begin
        case (bus.fan_state)
          FAN_OFF: period = CNT_W'(CHG_MS0);
          FAN_S1:  period = CNT_W'(CHG_MS1);
          FAN_S2:  period = CNT_W'(CHG_MS2);
          default: period = CNT_W'(CHG_MS3);
        endcase
      end
      PH_DIS: begin
        case (bus.fan_state)
          FAN_S1:  period = CNT_W'(DIS_MS1);
          FAN_S2:  period = CNT_W'(DIS_MS2);
          default: period = CNT_W'(DIS_MS3);
        endcase
      end
      default: period = CNT_W'(1);
    endcase
  end

  period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .tick   (bus.tick_ms),
    .period (period),
    .step   (step)
  );

  // Saturating level update and the hysteresis flags computed from the new level
  always_comb begin
    level_next = level_q;
    if (step && (cur_phase == PH_CHG) && (level_q < LVL_MAX)) begin
      level_next = level_q + LEVEL_W'(1);
    end else if (step && (cur_phase == PH_DIS) && (level_q != '0)) begin
      level_next = level_q - LEVEL_W'(1);
    end

    low_next = low_q;
    if (level_next <= LVL_LOW_SET) begin
      low_next = 1'b1;
    end else if (level_next >= LVL_LOW_CLR) begin
      low_next = 1'b0;
    end

    stop_next = stop_q;
    if (level_next == '0) begin
      stop_next = 1'b1;
    end else if (level_next >= LVL_RESTART) begin
      stop_next = 1'b0;
    end
  end

  // Remember last cycle's phase and fan speed to detect mode changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_HOLD;
      fan_q   <= FAN_OFF;
    end else begin
      phase_q <= cur_phase;
      fan_q   <= bus.fan_state;
    end
  end

  // Level and all flags move together on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LVL_INIT;
      empty_q <= INIT_EMPTY;
      full_q  <= INIT_FULL;
      low_q   <= INIT_LOW;
      stop_q  <= INIT_STOP;
    end else begin
      level_q <= level_next;
      empty_q <= (level_next == '0);
      full_q  <= (level_next == LVL_MAX);
      low_q   <= low_next;
      stop_q  <= stop_next;
    end
  end

  assign bus.level    = level_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.low_warn = low_q;
  assign bus.stop_req = stop_q;
  assign bus.phase    = phase_q;

endmodule
